seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver for the chess-clock front panel. Replaces per-digit static decoding with one shared segment bus plus per-digit anode enables. Adds:
- double-buffered digit capture
- leading-zero blanking
- per-digit blinking (flagging the running player or a flag-fall)
- selectable output polarity

Sits between the time counters/BCD logic and the board display pins.

---
 rtl/seg7_scan_driver.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: shadowed digits, leading-zero blanking, per-digit blink, polarity select.
// Optional feature macro SEG7_SCAN_HEX_EN: nibbles 10..15 show as A b C d E F instead of blank.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    CE,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int PRESC_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic                  INV     = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = INV ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h00;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
`ifdef SEG7_SCAN_HEX_EN
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                    phase_q, phase_d;
    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    presc_wrap, idx_last, frame_wrap, frame_last;
    logic [NUM_DIGITS-1:0]   lz_keep;
    logic [3:0]              cur_nib;
    logic                    blank;
    logic [6:0]              seg_ah;
    logic                    dp_ah;
    logic [NUM_DIGITS-1:0]   an_ah;

    assign presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign idx_last   = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = presc_wrap && idx_last;
    assign frame_last = (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1));

    // A digit survives leading-zero blanking once any nibble at or above it is nonzero.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_keep = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (dig_q[4*i +: 4] != 4'h0);
            lz_keep[i] = seen || (i == 0);
        end
    end

    assign cur_nib = dig_q[{idx_q, 2'b00} +: 4];
    assign blank   = ((LZ_BLANK != 0) && !lz_keep[idx_q]) || (phase_q && blink_q[idx_q]);
    assign seg_ah  = blank ? 7'h00 : decode(cur_nib);
    assign dp_ah   = !blank && dp_q[idx_q];
    assign an_ah   = NUM_DIGITS'(1) << idx_q;

    // NOTE: every next-state signal takes its held value first, so no path through this block can infer a latch.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        dig_d        = dig_q;
        dp_d         = dp_q;
        blink_d      = blink_q;
        seg_d        = seg_q;
        dp_out_d     = dp_out_q;
        an_d         = an_q;
        frame_done_d = 1'b0;
        if (CE) begin
            if (load) begin
                dig_d   = digits;
                dp_d    = dp_in;
                blink_d = blink_mask;
            end
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) begin
                idx_d = idx_last ? '0 : idx_q + 1'b1;
            end
            if (frame_wrap) begin
                frame_done_d = 1'b1;
                if (frame_last) begin
                    frame_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            // Outputs sample the pre-edge index and shadows, so a load shows one CE cycle later.
            seg_d    = INV ? ~seg_ah : seg_ah;
            dp_out_d = INV ? ~dp_ah  : dp_ah;
            an_d     = INV ? ~an_ah  : an_ah;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    // NOTE: the shadow digit registers are reset too, so a fresh power-up shows a defined "0".
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            dig_q        <= '0;
            dp_q         <= '0;
            blink_q      <= '0;
            seg_q        <= SEG_OFF;
            dp_out_q     <= INV;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            dig_q        <= dig_d;
            dp_q         <= dp_d;
            blink_q      <= blink_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, SCAN_DIV=4, BLINK_FRAMES=2, active-low, LZ on).
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        CE;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;   // CE-qualified edges since reset release

    logic [3:0] an_of    [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] seg_0050 [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};

    always #5 CLK = ~CLK;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .BLINK_FRAMES(2),
        .ACTIVE_LOW  (1),
        .LZ_BLANK    (1)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .CE        (CE),
        .load      (load),
        .digits    (digits),
        .dp_in     (dp_in),
        .blink_mask(blink_mask),
        .seg       (seg),
        .dp_out    (dp_out),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        if (CE && !CLR) cyc++;
    endtask

    // Advance to the first cycle in which output slot s is displayed.
    task automatic goto_slot(input int s);
        step();
        for (int i = 0; i < 16 && ((cyc - 1) % 16 != 4 * s); i++) step();
    endtask

    initial begin
        int s;
        int ph;
        CLR = 1'b1; CE = 1'b1; load = 1'b0;
        digits = 16'h0; dp_in = 4'h0; blink_mask = 4'h0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp_out, 1'b1);
        check("rst_an", an, 4'hF);
        check("rst_fd", frame_done, 1'b0);

        // Scan of 1234 with load coinciding with the first edge after release
        digits = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        CLR = 1'b0; cyc = 0;
        step();
        check("first_an", an, 4'hE);
        check("preload_seg", seg, 7'h40);
        load = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            step();
            s = ((cyc - 1) / 4) % 4;
            check($sformatf("scan_an_%0d", k), an, an_of[s]);
            check($sformatf("scan_seg_%0d", k), seg, seg_1234[s]);
            check($sformatf("scan_dp_%0d", k), dp_out, (s == 2) ? 1'b0 : 1'b1);
            check($sformatf("scan_fd_%0d", k), frame_done, (cyc % 16 == 0) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset mid-scan
        step(); step();
        #3 CLR = 1'b1;
        #1;
        check("mid_rst_seg", seg, 7'h7F);
        check("mid_rst_dp", dp_out, 1'b1);
        check("mid_rst_an", an, 4'hF);
        check("mid_rst_fd", frame_done, 1'b0);
        @(posedge CLK);
        #1;
        CLR = 1'b0; cyc = 0;
        step();
        check("post_rst_an", an, 4'hE);
        check("post_rst_seg", seg, 7'h40);

        // Leading-zero blanking
        digits = 16'h0050; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            goto_slot(k);
            check($sformatf("lz_an_%0d", k), an, an_of[k]);
            check($sformatf("lz_seg_%0d", k), seg, seg_0050[k]);
            check($sformatf("lz_dp_%0d", k), dp_out, 1'b1);
        end

        // Blink on digit 0, dp included
        digits = 16'h0009; dp_in = 4'b0001; blink_mask = 4'b0001; load = 1'b1;
        step();
        load = 1'b0;
        for (int f = 0; f < 6; f++) begin
            goto_slot(0);
            ph = ((cyc - 1) / 32) % 2;
            check($sformatf("blink_seg_%0d", f), seg, (ph == 1) ? 7'h7F : 7'h10);
            check($sformatf("blink_dp_%0d", f), dp_out, (ph == 1) ? 1'b1 : 1'b0);
        end

        // CE hold and shadow capture
        digits = 16'h0003; dp_in = 4'h0; blink_mask = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        goto_slot(0);
        check("pre_hold_seg", seg, 7'h30);
        step();
        CE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                digits = 16'h0008;
                load   = 1'b1;
            end
            step();
            check($sformatf("hold_an_%0d", i), an, 4'hE);
            check($sformatf("hold_seg_%0d", i), seg, 7'h30);
            check($sformatf("hold_fd_%0d", i), frame_done, 1'b0);
        end
        load = 1'b0;
        CE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("resume_an_%0d", i), an, an_of[((cyc - 1) / 4) % 4]);
        end
        goto_slot(0);
        check("noload_seg", seg, 7'h30);
        digits = 16'h0007; load = 1'b1;
        step();
        check("load_edge_seg", seg, 7'h30);
        load = 1'b0;
        step();
        check("load_next_seg", seg, 7'h78);

        // Nibble 10
        digits = 16'h000A; load = 1'b1;
        step();
        load = 1'b0;
        goto_slot(0);
`ifdef SEG7_SCAN_HEX_EN
        check("hex_a_seg", seg, 7'h08);
`else
        check("hex_a_seg", seg, 7'h7F);
`endif
        goto_slot(1);
        check("hex_d1_seg", seg, 7'h7F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
